// File: rtl/md5_msg_padder_if.sv
// Byte-stream input, MD5 block-core handshake and digest output of md5_msg_padder.
// The padder uses the slave modport; the message source / core environment uses master.
interface md5_msg_padder_if;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         in_empty;
   logic [511:0] core_block;
   logic         core_start;
   logic         core_resume;
   logic         core_done;
   logic [127:0] core_hash;
   logic [127:0] digest;
   logic         digest_valid;
   logic         busy;

   modport slave (
      input  in_valid, in_data, in_last, in_empty, core_done, core_hash,
      output in_ready, core_block, core_start, core_resume, digest, digest_valid, busy
   );

   modport master (
      output in_valid, in_data, in_last, in_empty, core_done, core_hash,
      input  in_ready, core_block, core_start, core_resume, digest, digest_valid, busy
   );
endinterface

// File: rtl/md5_msg_padder.sv
// MD5 message padder: buffers a byte stream into 512-bit blocks, appends 0x80/zeros/bit length,
// and sequences the block core. Optional MD5_PADDER_DIGEST_HOLD_EN registers and holds the digest.
module md5_msg_padder #(
   parameter int LEN_W = 61
) (
   input  logic              clk,
   input  logic              rst_n,
   md5_msg_padder_if.slave   bus
);

   typedef enum logic [2:0] {FILL, PAD, ISSUE, WAIT, DONE} state_e;

   state_e             state_q, state_d;
   logic [6:0]         idx_q, idx_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               first_q, first_d;
   logic               final_q, final_d;
   logic               pend_q, pend_d;
   logic               mark_q, mark_d;
   logic               stale_q, stale_d;
   logic               busy_q, busy_d;
   logic [511:0]       blk_q, blk_d;
   logic [63:0]        bit_len;
   logic               fire, has_byte, fits;

   assign bit_len  = 64'({cnt_q, 3'b000});
   assign fire     = bus.in_valid && (state_q == FILL);
   assign has_byte = !(bus.in_last && bus.in_empty);
   // Length fits in this block if the marker went in an earlier block or lands at byte <= 55.
   assign fits     = mark_q || (idx_q <= 7'd55);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      final_d = final_q;
      pend_d  = pend_q;
      mark_d  = mark_q;
      stale_d = stale_q;
      busy_d  = busy_q;
      blk_d   = blk_q;
      case (state_q)
         FILL: begin
            if (fire) begin
               busy_d = 1'b1;
               if (has_byte) begin
                  blk_d[{idx_q[5:0], 3'b000} +: 8] = bus.in_data;
                  idx_d = idx_q + 7'd1;
                  cnt_d = cnt_q + 1'b1;
               end
               if (bus.in_last) begin
                  state_d = PAD;
               end else if (has_byte && idx_q == 7'd63) begin
                  state_d = ISSUE;
                  final_d = 1'b0;
               end
            end
         end
         PAD: begin
            // idx=64 (block full on in_last) writes nothing; the marker goes in the next block.
            for (int b = 0; b < 64; b++) begin
               if (7'(b) >= idx_q)
                  blk_d[8*b +: 8] = (7'(b) == idx_q && !mark_q) ? 8'h80 : 8'h00;
               if (fits && b >= 56)
                  blk_d[8*b +: 8] = bit_len[8*(b-56) +: 8];
            end
            mark_d  = mark_q || !idx_q[6];
            final_d = fits;
            pend_d  = !fits;
            state_d = ISSUE;
         end
         ISSUE: begin
            first_d = 1'b0;
            stale_d = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            if (stale_q) begin
               stale_d = 1'b0;
            end else if (bus.core_done) begin
               idx_d = 7'd0;
               if (final_q)     state_d = DONE;
               else if (pend_q) state_d = PAD;
               else             state_d = FILL;
            end
         end
         DONE: begin
            state_d = FILL;
            idx_d   = 7'd0;
            cnt_d   = '0;
            first_d = 1'b1;
            final_d = 1'b0;
            pend_d  = 1'b0;
            mark_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         idx_q   <= 7'd0;
         cnt_q   <= '0;
         first_q <= 1'b1;
         final_q <= 1'b0;
         pend_q  <= 1'b0;
         mark_q  <= 1'b0;
         stale_q <= 1'b0;
         busy_q  <= 1'b0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         final_q <= final_d;
         pend_q  <= pend_d;
         mark_q  <= mark_d;
         stale_q <= stale_d;
         busy_q  <= busy_d;
         blk_q   <= blk_d;
      end
   end

   assign bus.in_ready    = (state_q == FILL);
   assign bus.core_start  = (state_q == ISSUE) && first_q;
   assign bus.core_resume = (state_q == ISSUE) && !first_q;
   assign bus.core_block  = blk_q;
   assign bus.busy        = busy_q;

`ifdef MD5_PADDER_DIGEST_HOLD_EN
   logic [127:0] digest_q;
   logic         dvld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digest_q <= '0;
         dvld_q   <= 1'b0;
      end else if (state_q == DONE) begin
         digest_q <= bus.core_hash;
         dvld_q   <= 1'b1;
      end else if (fire) begin
         dvld_q   <= 1'b0;
      end
   end

   assign bus.digest       = digest_q;
   assign bus.digest_valid = dvld_q;
`else
   assign bus.digest       = bus.core_hash;
   assign bus.digest_valid = (state_q == DONE);
`endif

endmodule

// File: tb/tb_md5_msg_padder.sv
// Bench for md5_msg_padder: an MD5 core model answers start/resume, and every block and digest
// is compared with a padding reference built from the message bytes.
module tb_md5_msg_padder;
   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   md5_msg_padder_if bus();
   md5_msg_padder #(.LEN_W(61)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // ---------------- MD5 arithmetic (used by core model and reference) ----------------
   logic [31:0] kt[64];
   int sh[4][4] = '{'{7,12,17,22}, '{5,9,14,20}, '{4,11,16,23}, '{6,10,15,21}};
   localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

   initial begin
      for (int i = 0; i < 64; i++) begin
         real s;
         s = $sin(real'(i + 1));
         if (s < 0.0) s = -s;
         kt[i] = 32'(longint'($floor(s * 4294967296.0)));
      end
   end

   function automatic logic [127:0] md5_blk(input logic [127:0] st, input logic [511:0] blk);
      logic [31:0] a, b, c, d, f, t;
      int g, s;
      {a, b, c, d} = st;
      for (int i = 0; i < 64; i++) begin
         case (i / 16)
            0:       begin f = (b & c) | (~b & d); g = i;                end
            1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
         endcase
         s = sh[i / 16][i % 4];
         t = f + a + kt[i] + blk[32 * g +: 32];
         a = d; d = c; c = b;
         b = b + ((t << s) | (t >> (32 - s)));
      end
      return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
   endfunction

   function automatic logic [31:0] bs(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [127:0] dig(input logic [127:0] st);
      return {bs(st[127:96]), bs(st[95:64]), bs(st[63:32]), bs(st[31:0])};
   endfunction

   // ---------------- MD5 core model: 68/67 cycle latency, done stays stale one cycle ----------------
   logic [127:0] chain;
   int cd;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.core_done <= 1'b0;
         bus.core_hash <= '0;
         chain         <= '0;
         cd            <= 0;
      end else if (bus.core_start || bus.core_resume) begin
         chain <= md5_blk(bus.core_start ? IV : chain, bus.core_block);
         cd    <= bus.core_start ? 67 : 66;
      end else if (cd == 1) begin
         bus.core_done <= 1'b1;
         bus.core_hash <= dig(chain);
         cd            <= 0;
      end else if (cd > 1) begin
         bus.core_done <= 1'b0;
         cd            <= cd - 1;
      end
   end

   // ---------------- monitor ----------------
   logic [511:0] got_blk[$];
   bit           got_st[$];
   logic [127:0] got_dig[$];
   logic         dv_prev = 1'b0;
   always @(negedge clk) begin
      if (bus.core_start || bus.core_resume) begin
         got_blk.push_back(bus.core_block);
         got_st.push_back(bus.core_start);
      end
      if (bus.digest_valid && !dv_prev) got_dig.push_back(bus.digest);
      dv_prev = bus.digest_valid;
   end

   // ---------------- reference padding ----------------
   logic [511:0] exp_blk[$];
   logic [127:0] exp_dig;

   task automatic ref_model(input bq_t msg);
      bq_t p;
      logic [63:0] bl;
      logic [127:0] st;
      logic [511:0] x;
      p = msg;
      bl = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      for (int k = 0; k < 8; k++) p.push_back(bl[8 * k +: 8]);
      exp_blk.delete();
      st = IV;
      for (int j = 0; j < p.size() / 64; j++) begin
         for (int i = 0; i < 64; i++) x[8 * i +: 8] = p[64 * j + i];
         exp_blk.push_back(x);
         st = md5_blk(st, x);
      end
      exp_dig = dig(st);
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // ---------------- stimulus ----------------
   // Called at a negedge; returns at a negedge. close adds a trailing empty in_last beat.
   task automatic send(input bq_t msg, input bit close);
      int n, beats, w;
      n = msg.size();
      beats = (close || n == 0) ? n + 1 : n;
      for (int k = 0; k < beats; k++) begin
         if ($urandom_range(3) == 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = (k < n) ? msg[k] : 8'h00;
         bus.in_last  = (k == beats - 1);
         bus.in_empty = (k >= n);
         w = 0;
         while (!bus.in_ready && w < 3000) begin
            @(negedge clk);
            w++;
         end
         if (w >= 3000) chk("ready_timeout", 1, 0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_empty = 1'b0;
      chk("rdy_drop", bus.in_ready, 0);
   endtask

   task automatic run_msg(input string tag, input bq_t msg, input bit close,
                          input bit has_k, input logic [127:0] kdig);
      int w;
      ref_model(msg);
      got_blk.delete(); got_st.delete(); got_dig.delete();
      send(msg, close);
      w = 0;
      while (got_dig.size() == 0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      chk({tag, "_nblk"}, got_blk.size(), exp_blk.size());
      for (int j = 0; j < got_blk.size() && j < exp_blk.size(); j++) begin
         chk($sformatf("%s_blk%0d", tag, j), got_blk[j], exp_blk[j]);
         chk($sformatf("%s_st%0d", tag, j), got_st[j], (j == 0));
      end
      chk({tag, "_ndig"}, got_dig.size(), 1);
      if (got_dig.size() > 0) begin
         chk({tag, "_dig"}, got_dig[0], exp_dig);
         if (has_k) chk({tag, "_known"}, got_dig[0], kdig);
      end
      chk({tag, "_idle"}, bus.busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t m;
      logic [511:0] b;
      int lens[10] = '{0, 1, 55, 56, 63, 64, 65, 119, 120, 128};
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b0;
      bus.in_empty = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.in_ready, 1);
      chk("rst_start", {bus.core_start, bus.core_resume}, 0);
      chk("rst_dvld", bus.digest_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_blk", bus.core_block, 0);
      chk("rst_dig", bus.digest, 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_msg("abc", str2q("abc"), 1'b0, 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72);
      m.delete();
      run_msg("empty", m, 1'b1, 1'b1, 128'hd41d8cd98f00b204e9800998ecf8427e);
      if (got_blk.size() > 0) begin
         b = got_blk[0];
         chk("empty_b0", b[7:0], 8'h80);
      end
      run_msg("m56", str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0,
              1'b1, 128'h8215ef0796a20bcaaae116d3876c664a);
      if (got_blk.size() > 1) begin
         b = got_blk[1];
         chk("m56_b56_57", b[8*56 +: 16], 16'h01c0);
      end
      m.delete();
      for (int i = 0; i < 64; i++) m.push_back(8'(8'h61 + i % 26));
      run_msg("m64", m, 1'b1, 1'b0, '0);
      if (got_blk.size() > 1) begin
         b = got_blk[1];
         chk("m64_b0", b[7:0], 8'h80);
         chk("m64_b56_57", b[8*56 +: 16], 16'h0200);
      end
      run_msg("abc2", str2q("abc"), 1'b0, 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72);
      run_msg("fox", str2q("The quick brown fox jumps over the lazy dog"), 1'b0,
              1'b1, 128'h9e107d9d372bb6826bd81d3542a419d6);

      // Reset while block 1 of "abc" is in the core.
      got_dig.delete();
      send(str2q("abc"), 1'b0);
      repeat (10) @(negedge clk);
      chk("wait_busy", bus.busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_ready", bus.in_ready, 1);
      chk("mid_start", {bus.core_start, bus.core_resume}, 0);
      chk("mid_dvld", bus.digest_valid, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_blk", bus.core_block, 0);
      chk("mid_dig", bus.digest, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("mid_nodig", got_dig.size(), 0);
      run_msg("abc3", str2q("abc"), 1'b0, 1'b1, 128'h900150983cd24fb0d6963f7d28e17f72);

      for (int r = 0; r < 12; r++) begin
         int n;
         n = (r < 10) ? lens[r] : int'($urandom_range(200));
         m.delete();
         for (int i = 0; i < n; i++) m.push_back(8'($urandom));
         run_msg($sformatf("rnd%0d", r), m, 1'($urandom_range(1)), 1'b0, '0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
